// File: rtl/instruction_decode_if.sv
// instruction_decode_if: fetch/write-back inputs and ID/EX latch outputs of the decode stage
interface instruction_decode_if #(parameter int B = 32);
  logic [B-1:0] pc_incrementado;
  logic [31:0]  instruction;
  logic         stall;
  logic         flush;
  logic         wb_reg_write;
  logic [4:0]   wb_write_reg;
  logic [B-1:0] wb_write_data;
  logic [B-1:0] ex_pc_inc;
  logic [B-1:0] ex_rd1;
  logic [B-1:0] ex_rd2;
  logic [B-1:0] ex_imm;
  logic [4:0]   ex_rs;
  logic [4:0]   ex_rt;
  logic [4:0]   ex_rd;
  logic [5:0]   ex_funct;
  logic [B-1:0] ex_jump_target;
  logic [10:0]  ex_ctrl;
  logic         ex_illegal;
  modport master (
    output pc_incrementado, instruction, stall, flush, wb_reg_write, wb_write_reg, wb_write_data,
    input  ex_pc_inc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, ex_jump_target, ex_ctrl, ex_illegal
  );
  modport slave (
    input  pc_incrementado, instruction, stall, flush, wb_reg_write, wb_write_reg, wb_write_data,
    output ex_pc_inc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, ex_jump_target, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/instruction_decode.sv
// instruction_decode: MIPS-subset decode, register file with WB bypass, and ID/EX latch
module instruction_decode #(
  parameter int B    = 32,
  parameter int NREG = 32
) (
  input logic clk,
  input logic reset,
  instruction_decode_if.slave bus
);
  logic [B-1:0]  r_regs [NREG];
  logic [5:0]    w_op;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [B-1:0]  w_rd1;
  logic [B-1:0]  w_rd2;
  logic [B-1:0]  w_imm;
  logic [10:0]   w_ctrl;
  logic          w_illegal;
  assign w_op = bus.instruction[31:26];
  assign w_rs = bus.instruction[25:21];
  assign w_rt = bus.instruction[20:16];
  // register reads: $0 is hard zero, a same-cycle write-back is forwarded
  always_comb begin
    w_rd1 = w_rs == 5'd0 ? '0 : (bus.wb_reg_write && bus.wb_write_reg == w_rs) ? bus.wb_write_data : r_regs[w_rs];
    w_rd2 = w_rt == 5'd0 ? '0 : (bus.wb_reg_write && bus.wb_write_reg == w_rt) ? bus.wb_write_data : r_regs[w_rt];
    w_imm = w_op[5:1] == 5'b00110 ? {{(B-16){1'b0}}, bus.instruction[15:0]}
                                  : {{(B-16){bus.instruction[15]}}, bus.instruction[15:0]};
  end
  // control decode; ctrl = {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,Jump,ALUOp}
  always_comb begin
    w_ctrl    = 11'b0;
    w_illegal = 1'b0;
    case (w_op)
      6'b000000: w_ctrl = 11'b1_0_0_1_0_0_0_0_0_10;
      6'b100011: w_ctrl = 11'b0_1_1_1_1_0_0_0_0_00;
      6'b101011: w_ctrl = 11'b0_1_0_0_0_1_0_0_0_00;
      6'b000100: w_ctrl = 11'b0_0_0_0_0_0_1_0_0_01;
      6'b000101: w_ctrl = 11'b0_0_0_0_0_0_1_1_0_01;
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111: w_ctrl = 11'b0_1_0_1_0_0_0_0_0_11;
      6'b000010: w_ctrl = 11'b0_0_0_0_0_0_0_0_1_00;
      default:   w_illegal = 1'b1;
    endcase
  end
  // register file write; writes to $0 are dropped so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
      r_regs[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end
  // ID/EX latch: flush inserts a bubble and beats stall, stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      bus.ex_pc_inc      <= '0;
      bus.ex_rd1         <= '0;
      bus.ex_rd2         <= '0;
      bus.ex_imm         <= '0;
      bus.ex_rs          <= '0;
      bus.ex_rt          <= '0;
      bus.ex_rd          <= '0;
      bus.ex_funct       <= '0;
      bus.ex_jump_target <= '0;
      bus.ex_ctrl        <= '0;
      bus.ex_illegal     <= 1'b0;
    end else if (!bus.stall) begin
      bus.ex_pc_inc      <= bus.pc_incrementado;
      bus.ex_rd1         <= w_rd1;
      bus.ex_rd2         <= w_rd2;
      bus.ex_imm         <= w_imm;
      bus.ex_rs          <= w_rs;
      bus.ex_rt          <= w_rt;
      bus.ex_rd          <= bus.instruction[15:11];
      bus.ex_funct       <= bus.instruction[5:0];
      bus.ex_jump_target <= {bus.pc_incrementado[B-1:B-4], bus.instruction[25:0], 2'b00};
      bus.ex_ctrl        <= w_ctrl;
      bus.ex_illegal     <= w_illegal;
    end
  end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vectors with hand-computed expectations for instruction_decode
module tb_instruction_decode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  instruction_decode_if #(.B(32)) bus ();
  instruction_decode #(.B(32), .NREG(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    bus.pc_incrementado = pc;
    bus.instruction     = ins;
  endtask
  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_reg_write  = en;
    bus.wb_write_reg  = r;
    bus.wb_write_data = d;
  endtask
  initial begin
    drive(32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", {21'b0, bus.ex_ctrl}, 32'h0);
    chk("reset_pc", bus.ex_pc_inc, 32'h0);
    reset = 1'b0;
    // write $5 = DEADBEEF under a NOP
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    drive(32'h4, 32'h0);
    tick();
    chk("nop_ctrl", {21'b0, bus.ex_ctrl}, 32'h482);
    chk("nop_illegal", {31'b0, bus.ex_illegal}, 32'h0);
    // addi $6,$5,-1
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h8, 32'h20A6FFFF);
    tick();
    chk("addi_rd1", bus.ex_rd1, 32'hDEADBEEF);
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
    chk("addi_ctrl", {21'b0, bus.ex_ctrl}, 32'h283);
    chk("addi_rs", {27'b0, bus.ex_rs}, 32'd5);
    chk("addi_rt", {27'b0, bus.ex_rt}, 32'd6);
    chk("addi_pc", bus.ex_pc_inc, 32'h8);
    // add $4,$3,$3 with same-cycle WB of $3
    wb(1'b1, 5'd3, 32'h1234);
    drive(32'hC, 32'h00632020);
    tick();
    chk("byp_rd1", bus.ex_rd1, 32'h1234);
    chk("byp_rd2", bus.ex_rd2, 32'h1234);
    chk("add_ctrl", {21'b0, bus.ex_ctrl}, 32'h482);
    chk("add_rd", {27'b0, bus.ex_rd}, 32'd4);
    chk("add_funct", {26'b0, bus.ex_funct}, 32'h20);
    // write to $0 is ignored, including by the bypass
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(32'h10, 32'h00000820);
    tick();
    chk("r0_byp", bus.ex_rd1, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_rd1", bus.ex_rd1, 32'h0);
    chk("r0_rd2", bus.ex_rd2, 32'h0);
    // lw $2,8($5), then hold for two cycles while writing $7
    drive(32'h14, 32'h8CA20008);
    tick();
    chk("lw_ctrl", {21'b0, bus.ex_ctrl}, 32'h3C0);
    chk("lw_imm", bus.ex_imm, 32'h8);
    bus.stall = 1'b1;
    wb(1'b1, 5'd7, 32'h77);
    drive(32'h99, 32'hACA20004);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("stall_ctrl", {21'b0, bus.ex_ctrl}, 32'h3C0);
    chk("stall_pc", bus.ex_pc_inc, 32'h14);
    chk("stall_rd1", bus.ex_rd1, 32'hDEADBEEF);
    chk("stall_imm", bus.ex_imm, 32'h8);
    bus.flush = 1'b1;
    tick();
    chk("flush_ctrl", {21'b0, bus.ex_ctrl}, 32'h0);
    chk("flush_pc", bus.ex_pc_inc, 32'h0);
    chk("flush_rd1", bus.ex_rd1, 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    // sw, beq, bne (the latter two read $7 written during the stall)
    tick();
    chk("sw_ctrl", {21'b0, bus.ex_ctrl}, 32'h220);
    drive(32'h20, 32'h10A70000);
    tick();
    chk("beq_ctrl", {21'b0, bus.ex_ctrl}, 32'h011);
    chk("beq_rd2", bus.ex_rd2, 32'h77);
    drive(32'h24, 32'h14A70000);
    tick();
    chk("bne_ctrl", {21'b0, bus.ex_ctrl}, 32'h019);
    // immediates: ori zero-extends, addi sign-extends, andi zero-extends
    drive(32'h28, 32'h34218000);
    tick();
    chk("ori_imm", bus.ex_imm, 32'h00008000);
    chk("ori_ctrl", {21'b0, bus.ex_ctrl}, 32'h283);
    drive(32'h2C, 32'h20218000);
    tick();
    chk("addi_neg_imm", bus.ex_imm, 32'hFFFF8000);
    drive(32'h30, 32'h3021F00F);
    tick();
    chk("andi_imm", bus.ex_imm, 32'h0000F00F);
    drive(32'h34, 32'h3C01ABCD);
    tick();
    chk("lui_ctrl", {21'b0, bus.ex_ctrl}, 32'h283);
    // jump target
    drive(32'h40000004, 32'h08000010);
    tick();
    chk("j_target", bus.ex_jump_target, 32'h40000040);
    chk("j_ctrl", {21'b0, bus.ex_ctrl}, 32'h004);
    // illegal opcode, then flush clears the flag
    drive(32'h38, 32'hFC000000);
    tick();
    chk("ill_ctrl", {21'b0, bus.ex_ctrl}, 32'h0);
    chk("ill_flag", {31'b0, bus.ex_illegal}, 32'h1);
    bus.flush = 1'b1;
    tick();
    chk("ill_flush", {31'b0, bus.ex_illegal}, 32'h0);
    bus.flush = 1'b0;
    // asynchronous reset mid-cycle with a live instruction latched
    drive(32'h3C, 32'h00A73820);
    tick();
    chk("pre_rst_rd1", bus.ex_rd1, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    chk("async_ctrl", {21'b0, bus.ex_ctrl}, 32'h0);
    chk("async_pc", bus.ex_pc_inc, 32'h0);
    chk("async_rd1", bus.ex_rd1, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_rd1", bus.ex_rd1, 32'h0);
    chk("post_rst_rd2", bus.ex_rd2, 32'h0);
    chk("post_rst_ctrl", {21'b0, bus.ex_ctrl}, 32'h482);
    drive(32'h40, 32'h00632020);
    tick();
    chk("post_rst_r3", bus.ex_rd1, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
